// File: rtl/pcie_tx_arbiter.sv
// Packet-atomic round-robin arbiter for the 7-series PCIe TX AXI-stream.
// Ports: user_* core status, s0_*/s1_* sources, m_* to core, status counters.
module pcie_tx_arbiter #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int BUF_AV_MIN   = 2
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic                    user_lnk_up,
  input  logic [5:0]              tx_buf_av,
  input  logic                    tx_err_drop,
  input  logic [C_DATA_WIDTH-1:0] s0_tdata,
  input  logic [KEEP_WIDTH-1:0]   s0_tkeep,
  input  logic [3:0]              s0_tuser,
  input  logic                    s0_tlast,
  input  logic                    s0_tvalid,
  output logic                    s0_tready,
  input  logic [C_DATA_WIDTH-1:0] s1_tdata,
  input  logic [KEEP_WIDTH-1:0]   s1_tkeep,
  input  logic [3:0]              s1_tuser,
  input  logic                    s1_tlast,
  input  logic                    s1_tvalid,
  output logic                    s1_tready,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0]   m_tkeep,
  output logic [3:0]              m_tuser,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [15:0]             pkt_cnt0,
  output logic [15:0]             pkt_cnt1,
  output logic [15:0]             drop_cnt,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   last_grant_nxt;
  logic   elig;
  logic   done0;
  logic   done1;

  assign elig  = user_lnk_up &&
                 (tx_buf_av >= 6'(BUF_AV_MIN));
  assign done0 = (state == GNT0) && s0_tvalid &&
                 m_tready && s0_tlast;
  assign done1 = (state == GNT1) && s1_tvalid &&
                 m_tready && s1_tlast;
  assign busy  = (state != IDLE);

  // Port 0 wins unless port 1 also requests and port 0 went last.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (elig) begin
          if (s0_tvalid && (!s1_tvalid || last_grant)) begin
            state_nxt      = GNT0;
            last_grant_nxt = 1'b0;
          end else if (s1_tvalid) begin
            state_nxt      = GNT1;
            last_grant_nxt = 1'b1;
          end
        end
      end
      GNT0: if (done0) state_nxt = IDLE;
      GNT1: if (done1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath mux; m_tready only reaches the granted source's tready.
  always_comb begin
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tuser   = '0;
    m_tlast   = 1'b0;
    m_tvalid  = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    unique case (1'b1)
      (state == GNT0): begin
        m_tdata   = s0_tdata;
        m_tkeep   = s0_tkeep;
        m_tuser   = s0_tuser;
        m_tlast   = s0_tlast;
        m_tvalid  = s0_tvalid;
        s0_tready = m_tready;
      end
      (state == GNT1): begin
        m_tdata   = s1_tdata;
        m_tkeep   = s1_tkeep;
        m_tuser   = s1_tuser;
        m_tlast   = s1_tlast;
        m_tvalid  = s1_tvalid;
        s1_tready = m_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (done0) pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (done1) pkt_cnt1 <= pkt_cnt1 + 16'd1;
      if (tx_err_drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: directed packets checked against an
// ownership model every cycle, plus literal checkpoints.
module tb_pcie_tx_arbiter;

  localparam int BMIN = 2;

  logic        user_clk = 1'b0;
  logic        user_reset = 1'b1;
  logic        user_lnk_up = 1'b1;
  logic [5:0]  tx_buf_av = 6'd10;
  logic        tx_err_drop = 1'b0;
  logic [63:0] s0_tdata = '0;
  logic [7:0]  s0_tkeep = '0;
  logic [3:0]  s0_tuser = '0;
  logic        s0_tlast = 1'b0;
  logic        s0_tvalid = 1'b0;
  logic        s0_tready;
  logic [63:0] s1_tdata = '0;
  logic [7:0]  s1_tkeep = '0;
  logic [3:0]  s1_tuser = '0;
  logic        s1_tlast = 1'b0;
  logic        s1_tvalid = 1'b0;
  logic        s1_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [3:0]  m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;
  logic [15:0] drop_cnt;
  logic        busy;

  pcie_tx_arbiter dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .user_lnk_up(user_lnk_up), .tx_buf_av(tx_buf_av),
    .tx_err_drop(tx_err_drop),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep),
    .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep),
    .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 user_clk = ~user_clk;

  int n_run = 0;
  int n_fail = 0;

  // model: who owns the bus (-1 none), who went last, counters
  int mo = -1;
  int ml = 1;
  int mp0 = 0;
  int mp1 = 0;
  int md = 0;
  int fd_gen = 0;
  int fd_val = 0;
  int fp_gen = 0;
  int fp_val = 0;
  logic [63:0] got[$];
  int dlog[$];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  initial begin : cmp
    int fd_seen;
    int fp_seen;
    logic pb;
    logic sv[2];
    logic sl[2];
    logic [63:0] sd[2];
    logic [7:0] sk[2];
    logic [3:0] su[2];
    logic ev, el;
    logic [63:0] ed;
    logic [7:0] ek;
    logic [3:0] eu;
    fd_seen = 0;
    fp_seen = 0;
    pb = 1'b0;
    forever begin
      @(negedge user_clk);
      #2;
      if (fd_gen != fd_seen) begin
        md = fd_val;
        fd_seen = fd_gen;
      end
      if (fp_gen != fp_seen) begin
        mp0 = fp_val;
        fp_seen = fp_gen;
      end
      sv[0] = s0_tvalid; sv[1] = s1_tvalid;
      sl[0] = s0_tlast;  sl[1] = s1_tlast;
      sd[0] = s0_tdata;  sd[1] = s1_tdata;
      sk[0] = s0_tkeep;  sk[1] = s1_tkeep;
      su[0] = s0_tuser;  su[1] = s1_tuser;
      ev = 0; el = 0; ed = 0; ek = 0; eu = 0;
      if (mo >= 0) begin
        ev = sv[mo]; el = sl[mo]; ed = sd[mo];
        ek = sk[mo]; eu = su[mo];
      end
      chk("busy", 64'(busy), 64'(mo >= 0));
      chk("m_tvalid", 64'(m_tvalid), 64'(ev));
      chk("m_tlast", 64'(m_tlast), 64'(el));
      chk("m_tdata", m_tdata, ed);
      chk("m_tkeep", 64'(m_tkeep), 64'(ek));
      chk("m_tuser", 64'(m_tuser), 64'(eu));
      chk("s0_tready", 64'(s0_tready),
          64'(mo == 0 && m_tready));
      chk("s1_tready", 64'(s1_tready),
          64'(mo == 1 && m_tready));
      chk("pkt_cnt0", 64'(pkt_cnt0), 64'(mp0));
      chk("pkt_cnt1", 64'(pkt_cnt1), 64'(mp1));
      chk("drop_cnt", 64'(drop_cnt), 64'(md));
      if (busy && !pb) dlog.push_back(s1_tready ? 1 : 0);
      pb = busy;
      if (m_tvalid && m_tready) got.push_back(m_tdata);
      // advance the model to the next edge
      if (user_reset) begin
        mo = -1; ml = 1; mp0 = 0; mp1 = 0; md = 0;
      end else begin
        if (tx_err_drop && md < 65535) md++;
        if (mo < 0) begin
          if (user_lnk_up && int'(tx_buf_av) >= BMIN) begin
            if (sv[0] && sv[1]) mo = 1 - ml;
            else if (sv[0]) mo = 0;
            else if (sv[1]) mo = 1;
            if (mo >= 0) ml = mo;
          end
        end else if (sv[mo] && m_tready && sl[mo]) begin
          if (mo == 0) mp0 = (mp0 + 1) % 65536;
          else mp1 = (mp1 + 1) % 65536;
          mo = -1;
        end
      end
    end
  end

  task automatic drv(int p, logic v, logic [63:0] d,
                     logic l);
    if (p == 0) begin
      s0_tvalid = v; s0_tdata = d; s0_tlast = l;
      s0_tkeep = v ? 8'hFF : 8'h00; s0_tuser = d[3:0];
    end else begin
      s1_tvalid = v; s1_tdata = d; s1_tlast = l;
      s1_tkeep = v ? 8'h0F : 8'h00; s1_tuser = d[3:0];
    end
  endtask

  task automatic send(int p, int n, logic [63:0] base,
                      int gap_at, int gap_len, bit stop);
    int i = 0;
    int g = 0;
    int cyc = 0;
    logic ack;
    while (i < n) begin
      @(negedge user_clk);
      if (i == gap_at && g < gap_len) begin
        drv(p, 1'b0, 64'h0, 1'b0);
        g++;
      end else begin
        drv(p, 1'b1, base + 64'(i), i == n - 1);
      end
      #3;
      ack = (p == 0) ? (s0_tvalid && s0_tready)
                     : (s1_tvalid && s1_tready);
      if (ack) i++;
      cyc++;
      if (cyc > 100) begin
        n_run++;
        n_fail++;
        $display("FAIL send_timeout port %0d beats %0d of %0d",
                 p, i, n);
        break;
      end
    end
    if (stop) begin
      @(negedge user_clk);
      drv(p, 1'b0, 64'h0, 1'b0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g0;
    int st;
    bit done4;
    // reset
    @(negedge user_clk);
    #2;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mvalid", 64'(m_tvalid), 0);
    chk("rst_pkt0", 64'(pkt_cnt0), 0);
    @(negedge user_clk);
    user_reset = 1'b0;

    // single 3-beat packet from s0
    g0 = got.size();
    send(0, 3, 64'h1000, -1, 0, 1);
    chk("t1_beats", 64'(got.size() - g0), 3);
    for (int i = 0; i < 3; i++)
      chk("t1_data", got[g0 + i], 64'h1000 + 64'(i));
    chk("t1_pkt0", 64'(pkt_cnt0), 1);

    // continuous contention: 0,1,0,1
    st = dlog.size();
    fork
      begin
        send(0, 2, 64'h2000, -1, 0, 0);
        send(0, 2, 64'h2010, -1, 0, 1);
      end
      begin
        @(negedge user_clk);
        send(1, 2, 64'h3000, -1, 0, 0);
        send(1, 2, 64'h3010, -1, 0, 1);
      end
    join
    chk("t2_ngrant", 64'(dlog.size() - st), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", 64'(dlog[st + i]), 64'(i % 2));
    chk("t2_pkt0", 64'(pkt_cnt0), 3);
    chk("t2_pkt1", 64'(pkt_cnt1), 2);

    // buffer space gating
    @(negedge user_clk);
    tx_buf_av = 6'd1;
    drv(1, 1'b1, 64'h4000, 1'b1);
    repeat (3) begin
      @(negedge user_clk);
      #2;
      chk("t3_buf_hold", 64'(busy), 0);
      chk("t3_buf_mvalid", 64'(m_tvalid), 0);
    end
    @(negedge user_clk);
    tx_buf_av = 6'd2;
    @(negedge user_clk);
    #2;
    chk("t3_buf_gnt", 64'(s1_tready), 1);
    @(negedge user_clk);
    drv(1, 1'b0, 64'h0, 1'b0);
    // link gating
    @(negedge user_clk);
    tx_buf_av = 6'd10;
    user_lnk_up = 1'b0;
    drv(1, 1'b1, 64'h4100, 1'b1);
    repeat (3) begin
      @(negedge user_clk);
      #2;
      chk("t3_lnk_hold", 64'(busy), 0);
    end
    @(negedge user_clk);
    user_lnk_up = 1'b1;
    @(negedge user_clk);
    #2;
    chk("t3_lnk_gnt", 64'(s1_tready), 1);
    @(negedge user_clk);
    drv(1, 1'b0, 64'h0, 1'b0);
    chk("t3_pkt1", 64'(pkt_cnt1), 4);

    // backpressure, source gap, link drop mid-packet
    g0 = got.size();
    done4 = 0;
    fork
      begin
        send(0, 4, 64'h5000, 2, 2, 1);
        done4 = 1;
      end
      begin
        int k;
        k = 0;
        while (!done4) begin
          @(negedge user_clk);
          m_tready = (k % 4 == 0) || (k % 4 == 3);
          k++;
          if (got.size() >= g0 + 2) user_lnk_up = 1'b0;
        end
      end
    join
    @(negedge user_clk);
    m_tready = 1'b1;
    user_lnk_up = 1'b1;
    chk("t4_beats", 64'(got.size() - g0), 4);
    for (int i = 0; i < 4; i++)
      chk("t4_data", got[g0 + i], 64'h5000 + 64'(i));
    chk("t4_pkt0", 64'(pkt_cnt0), 4);

    // reset in the middle of a GNT1 packet
    @(negedge user_clk);
    drv(1, 1'b1, 64'h6000, 1'b0);
    @(negedge user_clk);
    @(negedge user_clk);
    user_reset = 1'b1;
    drv(0, 1'b1, 64'h6100, 1'b1);
    @(negedge user_clk);
    #2;
    chk("t5_busy", 64'(busy), 0);
    chk("t5_mvalid", 64'(m_tvalid), 0);
    chk("t5_rdy0", 64'(s0_tready), 0);
    chk("t5_rdy1", 64'(s1_tready), 0);
    chk("t5_pkt0", 64'(pkt_cnt0), 0);
    chk("t5_pkt1", 64'(pkt_cnt1), 0);
    @(negedge user_clk);
    user_reset = 1'b0;
    @(negedge user_clk);
    #2;
    chk("t5_first0", 64'(s0_tready), 1);
    chk("t5_not1", 64'(s1_tready), 0);
    @(negedge user_clk);
    drv(0, 1'b0, 64'h0, 1'b0);
    drv(1, 1'b1, 64'h6001, 1'b1);
    @(negedge user_clk);
    @(negedge user_clk);
    drv(1, 1'b0, 64'h0, 1'b0);

    // drop counter, coincident with a tlast accept
    @(negedge user_clk);
    tx_err_drop = 1'b1;
    @(negedge user_clk);
    tx_err_drop = 1'b0;
    fork
      send(0, 2, 64'h7000, -1, 0, 1);
      begin
        @(negedge user_clk);
        @(negedge user_clk);
        @(negedge user_clk);
        tx_err_drop = 1'b1;
        @(negedge user_clk);
        tx_err_drop = 1'b0;
      end
    join
    @(negedge user_clk);
    tx_err_drop = 1'b1;
    @(negedge user_clk);
    tx_err_drop = 1'b0;
    @(negedge user_clk);
    #2;
    chk("t6_drop", 64'(drop_cnt), 3);
    chk("t6_pkt0", 64'(pkt_cnt0), 2);

    // drop saturation
    @(negedge user_clk);
    force dut.drop_cnt = 16'hFFFE;
    fd_val = 16'hFFFE;
    fd_gen++;
    #1;
    release dut.drop_cnt;
    @(negedge user_clk);
    tx_err_drop = 1'b1;
    @(negedge user_clk);
    @(negedge user_clk);
    tx_err_drop = 1'b0;
    @(negedge user_clk);
    #2;
    chk("t6_drop_sat", 64'(drop_cnt), 64'hFFFF);

    // packet counter wrap
    @(negedge user_clk);
    force dut.pkt_cnt0 = 16'hFFFF;
    fp_val = 16'hFFFF;
    fp_gen++;
    #1;
    release dut.pkt_cnt0;
    send(0, 1, 64'h8000, -1, 0, 1);
    #2;
    chk("t6_pkt0_wrap", 64'(pkt_cnt0), 0);

    repeat (3) @(negedge user_clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
